// File: rtl/bexkat1_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Covers the grant states, the master indices and the tie-break rule.
package bexkat1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } gnt_state_t;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  // On a tie, round-robin hands the bus to whoever did not have it last.
  // Otherwise the data port (master 1) wins.
  function automatic gnt_state_t pick_grant(input logic req0, input logic req1,
                                            input logic last_gnt, input logic fair);
    gnt_state_t pick;
    pick = IDLE;
    if (req0 && req1) begin
      if (fair) pick = (last_gnt == MASTER0) ? GNT1 : GNT0;
      else      pick = GNT1;
    end else if (req0) begin
      pick = GNT0;
    end else if (req1) begin
      pick = GNT1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts unacknowledged strobe cycles and produces a one-cycle err pulse
// once TIMEOUT of them have gone by without an ack.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic ack,
  input  logic restart,
  output logic err
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] count_q;
  logic        err_q;
  logic        expire;

  // A grant change at the same edge hands the bus to someone else, so no pulse.
  assign expire = stb && !ack && !restart && (count_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= expire;
      if (restart || !stb || ack || expire) count_q <= '0;
      else                                  count_q <= count_q + 16'd1;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter: instruction fetch (m0, read-only)
// and data port (m1) share one slave; the grant is held for the owner's whole cyc.
module bus_arbiter
  import bexkat1_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 255,
  parameter int FAIR    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic [AWIDTH-1:0] m0_adr_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [AWIDTH-1:0] m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [AWIDTH-1:0] s_adr_o,
  output logic [31:0]       s_dat_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  localparam logic FAIR_TIE = (FAIR != 0);

  gnt_state_t state_q, state_d;
  logic       last_gnt_q;
  logic       grant_change;
  logic       wd_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= MASTER0;
    end else begin
      state_q <= state_d;
      if (state_d == GNT0)      last_gnt_q <= MASTER0;
      else if (state_d == GNT1) last_gnt_q <= MASTER1;
    end
  end

  // Re-arbitrate only when the bus is free or its owner has released cyc.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_grant(m0_cyc_i, m1_cyc_i, last_gnt_q, FAIR_TIE);
      GNT0:    if (!m0_cyc_i) state_d = pick_grant(m0_cyc_i, m1_cyc_i, last_gnt_q, FAIR_TIE);
      GNT1:    if (!m1_cyc_i) state_d = pick_grant(m0_cyc_i, m1_cyc_i, last_gnt_q, FAIR_TIE);
      default: state_d = IDLE;
    endcase
  end

  assign grant_change = (state_d != state_q);

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .stb    (s_stb_o),
    .ack    (s_ack_i),
    .restart(grant_change),
    .err    (wd_err)
  );

  // A late ack in the err cycle wins, so err is masked by s_ack_i.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = '0;
    s_dat_o  = 32'h0;
    m0_dat_o = 32'h0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    case (state_q)
      GNT0: begin
        gnt_o    = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i;
        s_sel_o  = 4'hf;
        s_adr_o  = m0_adr_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = wd_err & ~s_ack_i;
      end
      GNT1: begin
        gnt_o    = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = wd_err & ~s_ack_i;
      end
      default: ;
    endcase
  end

endmodule
